// File: rtl/pin_sender.sv
// rtl/pin_sender.sv - nibble-serial PIN sender for the safe lock, with timeout and pass/fail report.
// Optional retry with lock reset pulses is built when PIN_SENDER_RETRY_EN is defined.
module pin_sender #(
  parameter int GAP_CYCLES  = 1,
  parameter int TIMEOUT     = 8,
  parameter int MAX_RETRIES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pin,
  input  logic        unlocked,
  output logic [3:0]  dout,
  output logic        dout_valid,
  output logic        safe_reset,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [1:0]  retries_used
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    WAIT,
`ifdef PIN_SENDER_RETRY_EN
    RST_SAFE,
`endif
    DONE
  } state_t;

`ifdef PIN_SENDER_RETRY_EN
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRIES != 0);
`endif

  state_t      state_q, state_d;
  logic [15:0] pin_q, pin_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        success_q, success_d;
  logic [1:0]  retries_q, retries_d;
  logic [3:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        safe_reset_q, safe_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d    = state_q;
    pin_d      = pin_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    wait_cnt_d = wait_cnt_q;
    success_d  = success_q;
    retries_d  = retries_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pin_d     = pin;
          idx_d     = 2'd0;
          success_d = 1'b0;
          retries_d = 2'd0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (idx_q == 2'd3) begin
          wait_cnt_d = 16'd0;
          state_d    = WAIT;
        end else begin
          idx_d     = idx_q + 2'd1;
          gap_cnt_d = 16'd0;
          state_d   = (GAP_CYCLES == 0) ? SEND : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) state_d = SEND;
        else gap_cnt_d = gap_cnt_q + 16'd1;
      end
      WAIT: begin
        if (unlocked) begin
          success_d = 1'b1;
          state_d   = DONE;
        end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
`ifdef PIN_SENDER_RETRY_EN
          state_d = (retries_q < RETRY_LIMIT) ? RST_SAFE : DONE;
`else
          state_d = DONE;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
`ifdef PIN_SENDER_RETRY_EN
      RST_SAFE: begin
        retries_d = retries_q + 2'd1;
        idx_d     = 2'd0;
        state_d   = SEND;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so each strobe lines up with its state's cycle.
    dout_valid_d = (state_d == SEND);
    dout_d       = dout_valid_d ? 4'(pin_d >> {~idx_d, 2'b00}) : 4'h0;
`ifdef PIN_SENDER_RETRY_EN
    safe_reset_d = (state_d == RST_SAFE);
`else
    safe_reset_d = 1'b0;
`endif
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pin_q        <= 16'h0000;
      idx_q        <= 2'd0;
      gap_cnt_q    <= 16'd0;
      wait_cnt_q   <= 16'd0;
      success_q    <= 1'b0;
      retries_q    <= 2'd0;
      dout_q       <= 4'h0;
      dout_valid_q <= 1'b0;
      safe_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pin_q        <= pin_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      success_q    <= success_d;
      retries_q    <= retries_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      safe_reset_q <= safe_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign safe_reset   = safe_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign success      = success_q;
  assign retries_used = retries_q;

endmodule

// File: tb/tb_pin_sender.sv
// tb/tb_pin_sender.sv - directed vectors for pin_sender against a small lock model.
module tb_pin_sender;

`ifdef PIN_SENDER_RETRY_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] pin = 16'h0000;
  logic        unlocked;
  logic [3:0]  dout_a, dout_b;
  logic        dv_a, dv_b, sr_a, sr_b, busy_a, busy_b, done_a, done_b, succ_a, succ_b;
  logic [1:0]  ret_a, ret_b;

  logic        sel = 1'b0, lock_en = 1'b0, force_unl = 1'b0, lock_clr = 1'b0, lock_unl;
  logic [15:0] lock_code = 16'h0000, lk_sh;
  logic [1:0]  lk_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pin_sender dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pin(pin), .unlocked(unlocked),
    .dout(dout_a), .dout_valid(dv_a), .safe_reset(sr_a), .busy(busy_a),
    .done(done_a), .success(succ_a), .retries_used(ret_a)
  );

  pin_sender #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pin(pin), .unlocked(unlocked),
    .dout(dout_b), .dout_valid(dv_b), .safe_reset(sr_b), .busy(busy_b),
    .done(done_b), .success(succ_b), .retries_used(ret_b)
  );

  wire [3:0] o_dout  = sel ? dout_b : dout_a;
  wire       o_valid = sel ? dv_b   : dv_a;
  wire       o_safe  = sel ? sr_b   : sr_a;
  wire       o_busy  = sel ? busy_b : busy_a;
  wire       o_done  = sel ? done_b : done_a;
  wire       o_succ  = sel ? succ_b : succ_a;
  wire [1:0] o_ret   = sel ? ret_b  : ret_a;

  assign unlocked = lock_en ? lock_unl : force_unl;

  // Lock: unlocks the cycle after the 4th nibble if the code matches.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_sh <= 16'h0; lk_cnt <= 2'd0; lock_unl <= 1'b0;
    end else if (lock_clr || o_safe) begin
      lk_sh <= 16'h0; lk_cnt <= 2'd0; lock_unl <= 1'b0;
    end else if (o_valid) begin
      lk_sh  <= {lk_sh[11:0], o_dout};
      lk_cnt <= lk_cnt + 2'd1;
      if (lk_cnt == 2'd3 && {lk_sh[11:0], o_dout} == lock_code) lock_unl <= 1'b1;
    end
  end

  typedef struct {
    logic [15:0] pin;
    logic [15:0] code;
    bit          lock_en;
    bit          sel;
    int          force_off;
    int          poke;
    int          gap;
    int          exp_done;
    bit          exp_succ;
    int          exp_ret;
    int          exp_strobes;
    int          exp_safe;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int cyc, nseen, strobes, safes, done_cyc, busy_bad, zero_bad, succ_at, ret_at;
    int nib_cyc[4];
    int nib_val[4];
    logic [15:0] p;
    string tag;
    tag = $sformatf("v%0d", id);
    nseen = 0; strobes = 0; safes = 0; done_cyc = -1; busy_bad = 0; zero_bad = 0;
    succ_at = -1; ret_at = -1;
    for (int k = 0; k < 4; k++) begin nib_cyc[k] = -1; nib_val[k] = -1; end
    sel = v.sel; lock_en = v.lock_en; lock_code = v.code; force_unl = (v.force_off > 0);
    lock_clr = 1'b1;
    @(negedge clk);
    lock_clr = 1'b0;
    pin = v.pin;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; pin = ~v.pin;
    cyc = 1;
    while (cyc < 200 && done_cyc < 0) begin
      force_unl = (cyc < v.force_off);
      if (o_valid) begin
        if (nseen < 4) begin nib_cyc[nseen] = cyc; nib_val[nseen] = int'(o_dout); nseen++; end
        strobes++;
      end else if (o_dout != 4'h0) zero_bad++;
      if (o_safe) safes++;
      if (o_busy != !o_done) busy_bad++;
      if (o_done) begin done_cyc = cyc; succ_at = int'(o_succ); ret_at = int'(o_ret); end
      if (cyc == v.poke) begin
        pin = 16'h0000;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    p = v.pin;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_nib_cycle"}, nib_cyc[k], 1 + k * (v.gap + 1));
      chk({tag, "_nib_value"}, nib_val[k], int'(p[15 - 4*k -: 4]));
    end
    chk({tag, "_strobes"}, strobes, v.exp_strobes);
    chk({tag, "_safe_reset_pulses"}, safes, v.exp_safe);
    chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
    chk({tag, "_success"}, succ_at, int'(v.exp_succ));
    chk({tag, "_retries_used"}, ret_at, v.exp_ret);
    chk({tag, "_busy_shape"}, busy_bad, 0);
    chk({tag, "_dout_zero_idle"}, zero_bad, 0);
    chk({tag, "_after_done"}, {o_done, o_busy, o_valid, o_succ, o_ret},
        {1'b0, 1'b0, 1'b0, v.exp_succ, 2'(v.exp_ret)});
  endtask

  initial begin
    vecs[0] = '{16'hC0DE, 16'hC0DE, 1'b1, 1'b0, 0, -1, 1, 9, 1'b1, 0, 4, 0};
    vecs[1] = '{16'hF00F, 16'hF00F, 1'b1, 1'b1, 0, -1, 0, 6, 1'b1, 0, 4, 0};
    vecs[2] = '{16'hA5A5, 16'hA5A5, 1'b1, 1'b0, 0, -1, 1, 9, 1'b1, 0, 4, 0};
    vecs[3] = '{16'h1234, 16'hC0DE, 1'b1, 1'b0, 0, -1, 1, RT ? 48 : 16, 1'b0,
                RT ? 2 : 0, RT ? 12 : 4, RT ? 2 : 0};
    vecs[4] = '{16'h1234, 16'hC0DE, 1'b1, 1'b1, 0, -1, 0, RT ? 39 : 13, 1'b0,
                RT ? 2 : 0, RT ? 12 : 4, RT ? 2 : 0};
    vecs[5] = '{16'hC0DE, 16'hC0DE, 1'b1, 1'b0, 0, 3, 1, 9, 1'b1, 0, 4, 0};
    vecs[6] = '{16'h1234, 16'hC0DE, 1'b0, 1'b0, 1000, -1, 1, 9, 1'b1, 0, 4, 0};
    vecs[7] = '{16'h1234, 16'hC0DE, 1'b0, 1'b0, 8, -1, 1, RT ? 48 : 16, 1'b0,
                RT ? 2 : 0, RT ? 12 : 4, RT ? 2 : 0};

    repeat (2) @(negedge clk);
    chk("reset_outputs_a", {dout_a, dv_a, sr_a, busy_a, done_a, succ_a, ret_a}, 0);
    chk("reset_outputs_b", {dout_b, dv_b, sr_b, busy_b, done_b, succ_b, ret_b}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {dout_a, dv_a, sr_a, busy_a, done_a, succ_a, ret_a}, 0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in cycle 4 of a run aborts it without done or safe_reset.
    begin
      int dones;
      dones = 0;
      sel = 1'b0; lock_en = 1'b1; lock_code = 16'hC0DE;
      pin = 16'hC0DE; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrun_busy_before_reset", int'(busy_a), 1);
      reset = 1'b1;
      #1;
      chk("midrun_async_clear", {dout_a, dv_a, sr_a, busy_a, done_a, succ_a, ret_a}, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (done_a || sr_a) dones++;
      end
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done_a || sr_a) dones++;
      end
      chk("midrun_no_done_after_abort", dones, 0);
      run_vec(8, vecs[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pin_sender.md
# pin_sender

Drives the nibble-serial PIN-entry interface of the safe lock from the initiator side. On a start request it latches a 16-bit PIN and emits its four nibbles, most significant first, on `dout`/`dout_valid` with a programmable gap. It then watches the lock's `unlocked` status until a timeout expires and reports pass or fail. Optionally, it pulses the lock's reset and retries. The block sits between test/control logic and the lock, so the lock can be exercised end-to-end without a host.

## Interface
- `GAP_CYCLES`, default 1: idle cycles inserted between consecutive nibbles (0 allowed, giving back-to-back nibbles).
- `TIMEOUT`, default 8: cycles to wait for `unlocked` after the last nibble (at least 1).
- `MAX_RETRIES`, default 2: extra attempts after a failed one (used only with `PIN_SENDER_RETRY_EN`).
- `clk` in 1: single clock; all logic rises on posedge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request to begin; sampled only in IDLE.
- `pin` in 16: PIN to send; `pin[15:12]` goes first; latched when `start` is accepted.
- `unlocked` in 1: status from the lock.
- `dout` out 4: nibble to the lock; 0 whenever `dout_valid` is low.
- `dout_valid` out 1: one-cycle strobe per nibble.
- `safe_reset` out 1: one-cycle reset pulse to the lock before each retry.
- `busy` out 1: high from start acceptance until `done`.
- `done` out 1: one-cycle completion pulse.
- `success` out 1: result; valid with `done` and held until the next accepted `start`.
- `retries_used` out 2: retries consumed in the last run; held until the next accepted `start`.

## Operation
- All outputs are registered. After reset every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, SEND, GAP, WAIT, RST_SAFE, DONE.
- IDLE:
  - When `start` is high, latch `pin` and clear the nibble index, attempt count, `success` and `retries_used`.
  - Go to SEND and set `busy`=1.
- SEND:
  - Hold one cycle with `dout_valid`=1 and `dout` = `pin_q[15-4*idx -: 4]`.
  - If idx=3, go to WAIT and clear the wait counter.
  - Otherwise increment idx and go to GAP, or go straight to SEND if `GAP_CYCLES`=0.
- GAP: count `GAP_CYCLES` cycles, then go to SEND.
- WAIT:
  - Each cycle, sample `unlocked`. If it is high, set `success`=1 and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT` with `unlocked` never seen, the attempt fails.
  - On a failed attempt, go to RST_SAFE if retries are enabled and attempts < `MAX_RETRIES`. Otherwise go to DONE with `success`=0.
- RST_SAFE:
  - Hold one cycle with `safe_reset`=1.
  - Increment `retries_used`, clear idx, then go to SEND.
- DONE:
  - Hold one cycle with `done`=1. `busy` drops in the same cycle.
  - Return to IDLE.
- `start` is ignored while `busy` is high. `pin` changes after acceptance have no effect.
- `unlocked` is ignored outside WAIT. An `unlocked` level left over from a previous run does not count until WAIT is entered.
- Asserting `reset` mid-run aborts immediately:
  - All outputs return to 0.
  - No `done` pulse is produced.
  - No `safe_reset` pulse is produced.

## Timing
- Cycle 0 is the edge where `start` is sampled. `busy`=1 from cycle 1.
- Nibble k (k = 0..3) has `dout_valid` high in cycle 1 + k·(`GAP_CYCLES`+1).
- WAIT starts in the cycle after the last nibble. The lock's `unlocked` rises one cycle after it accepts the 4th nibble, so it is seen in the first WAIT cycle and `done` follows in the next cycle.
  - With defaults and a correct PIN: nibbles in cycles 1, 3, 5, 7; WAIT in cycle 8; `done` in cycle 9.
- A failed attempt occupies exactly `TIMEOUT` WAIT cycles.
- Each retry adds the RST_SAFE cycle plus the full send sequence.

## Configuration
- `PIN_SENDER_RETRY_EN` defined: the RST_SAFE state and retry logic are built in, up to `MAX_RETRIES` retries.
- `PIN_SENDER_RETRY_EN` undefined:
  - A single attempt only; a timeout goes directly to DONE with `success`=0.
  - `safe_reset` and `retries_used` are tied to 0.
  - The RST_SAFE state is absent.

## Test plan
- Correct PIN, defaults: `pin`=0xC0DE with the lock attached → `dout` is C, 0, D, E in cycles 1, 3, 5, 7; `done`=1 in cycle 9 with `success`=1 and `retries_used`=0.
- Alternate code, `GAP_CYCLES`=0: `pin`=0xF00F → nibbles F, 0, 0, F in cycles 1–4; `success`=1.
- Wrong PIN with retry enabled: `pin`=0x1234 and `unlocked` held at 0 → exactly 3 send sequences and 2 `safe_reset` pulses; `done` with `success`=0 and `retries_used`=2. With the macro undefined: 1 send sequence, `done` at cycle 7+8+1=16, no `safe_reset` pulse.
- Start while busy: pulse `start` with `pin`=0x0000 at cycle 3 of a 0xC0DE run → ignored; the nibble stream is unchanged.
- Reset mid-operation: assert `reset` in cycle 4 → all outputs 0 asynchronously and no `done` pulse. A new `start` after release runs cleanly from nibble 0.
- Stale `unlocked`: hold `unlocked`=1 throughout the send phase with a wrong PIN → `success` is set only because `unlocked` is still high in WAIT. Then drop `unlocked` before WAIT → timeout failure.
